// File: rtl/game_session_ctrl.sv
// game_session_ctrl: session FSM for Frogger (IDLE/RUNNING/HIT/GAME_OVER) with lives,
//   respawn delay, game-over hold, best-level record and optional history writes.
// Optional feature macro: SESSION_HISTORY_EN (history log over the register-file write port).
// Ports: i_Clk, i_Rst_L (async active-low), i_Start, i_Has_Collided, i_Level_Up in;
//   o_Game_Active, o_Frog_Reset, o_Lives[1:0], o_Level[7:0], o_Best_Level[7:0], o_Game_Over,
//   o_Write_En, o_Write_Addr[4:0], o_Write_Data[7:0] out. All outputs registered.
module game_session_ctrl #(
   parameter int C_LIVES_INI        = 3,
   parameter int C_RESPAWN_CYCLES   = 25_000_000,
   parameter int C_GAME_OVER_CYCLES = 75_000_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Start,
   input  logic       i_Has_Collided,
   input  logic       i_Level_Up,
   output logic       o_Game_Active,
   output logic       o_Frog_Reset,
   output logic [1:0] o_Lives,
   output logic [7:0] o_Level,
   output logic [7:0] o_Best_Level,
   output logic       o_Game_Over,
   output logic       o_Write_En,
   output logic [4:0] o_Write_Addr,
   output logic [7:0] o_Write_Data
);

   localparam int C_TIMER_MAX = (C_RESPAWN_CYCLES > C_GAME_OVER_CYCLES) ?
                                C_RESPAWN_CYCLES : C_GAME_OVER_CYCLES;
   localparam int TW = $clog2(C_TIMER_MAX);

   typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_HIT, S_GAME_OVER} state_t;

   state_t          r_State;
   logic [TW-1:0]   r_Timer;
   logic            r_Start_Q;
   logic            r_Coll_Q;
   logic            start_rise;
   logic            coll_rise;

   // Edge detection: a held switch or a lingering collision level must not retrigger.
   assign start_rise = i_Start & ~r_Start_Q;
   assign coll_rise  = i_Has_Collided & ~r_Coll_Q;

`ifdef SESSION_HISTORY_EN
   logic [4:0] r_Ptr;
`else
   assign o_Write_En   = 1'b0;
   assign o_Write_Addr = 5'd0;
   assign o_Write_Data = 8'd0;
`endif

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State       <= S_IDLE;
         r_Timer       <= '0;
         r_Start_Q     <= 1'b0;
         r_Coll_Q      <= 1'b0;
         o_Game_Active <= 1'b0;
         o_Frog_Reset  <= 1'b0;
         o_Lives       <= 2'd0;
         o_Level       <= 8'd0;
         o_Best_Level  <= 8'd0;
         o_Game_Over   <= 1'b0;
`ifdef SESSION_HISTORY_EN
         r_Ptr         <= 5'd0;
         o_Write_En    <= 1'b0;
         o_Write_Addr  <= 5'd0;
         o_Write_Data  <= 8'd0;
`endif
      end else begin
         r_Start_Q    <= i_Start;
         r_Coll_Q     <= i_Has_Collided;
         o_Frog_Reset <= 1'b0;
`ifdef SESSION_HISTORY_EN
         o_Write_En   <= 1'b0;
`endif
         case (r_State)
            S_IDLE: begin
               if (start_rise) begin
                  r_State       <= S_RUNNING;
                  o_Game_Active <= 1'b1;
                  o_Frog_Reset  <= 1'b1;
                  o_Lives       <= 2'(C_LIVES_INI);
                  o_Level       <= 8'd0;
               end
            end
            S_RUNNING: begin
               // Collision has priority; a coincident level-up is dropped.
               if (coll_rise) begin
                  r_State       <= S_HIT;
                  o_Game_Active <= 1'b0;
                  o_Lives       <= o_Lives - 2'd1;
                  r_Timer       <= TW'(C_RESPAWN_CYCLES - 1);
               end else if (i_Level_Up && (o_Level != 8'hFF)) begin
                  o_Level <= o_Level + 8'd1;
               end
            end
            S_HIT: begin
               if (r_Timer == '0) begin
                  if (o_Lives == 2'd0) begin
                     r_State     <= S_GAME_OVER;
                     o_Game_Over <= 1'b1;
                     r_Timer     <= TW'(C_GAME_OVER_CYCLES - 1);
                     // Best-level and history are updated so they are visible
                     // on the first GAME_OVER cycle.
                     if (o_Level > o_Best_Level)
                        o_Best_Level <= o_Level;
`ifdef SESSION_HISTORY_EN
                     o_Write_En   <= 1'b1;
                     o_Write_Addr <= r_Ptr;
                     o_Write_Data <= o_Level;
                     r_Ptr        <= r_Ptr + 5'd1;
`endif
                  end else begin
                     r_State       <= S_RUNNING;
                     o_Game_Active <= 1'b1;
                     o_Frog_Reset  <= 1'b1;
                  end
               end else begin
                  r_Timer <= r_Timer - TW'(1);
               end
            end
            S_GAME_OVER: begin
               if (r_Timer == '0) begin
                  r_State     <= S_IDLE;
                  o_Game_Over <= 1'b0;
               end else begin
                  r_Timer <= r_Timer - TW'(1);
               end
            end
            default: r_State <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_session_ctrl.sv
// tb_game_session_ctrl: table-driven directed sequence, async-reset check, 33-session
// history sequence and randomized run against a cycle-count reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_game_session_ctrl;

   localparam int C_LI = 3;
   localparam int C_R  = 4;
   localparam int C_G  = 8;
`ifdef SESSION_HISTORY_EN
   localparam bit HIST = 1'b1;
`else
   localparam bit HIST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, coll = 1'b0, lvl = 1'b0;
   logic       o_Game_Active, o_Frog_Reset, o_Game_Over, o_Write_En;
   logic [1:0] o_Lives;
   logic [7:0] o_Level, o_Best_Level, o_Write_Data;
   logic [4:0] o_Write_Addr;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   game_session_ctrl #(
      .C_LIVES_INI(C_LI), .C_RESPAWN_CYCLES(C_R), .C_GAME_OVER_CYCLES(C_G)
   ) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Has_Collided(coll),
      .i_Level_Up(lvl), .o_Game_Active(o_Game_Active), .o_Frog_Reset(o_Frog_Reset),
      .o_Lives(o_Lives), .o_Level(o_Level), .o_Best_Level(o_Best_Level),
      .o_Game_Over(o_Game_Over), .o_Write_En(o_Write_En), .o_Write_Addr(o_Write_Addr),
      .o_Write_Data(o_Write_Data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: phases with remaining-cycle counts ----------
   localparam int P_IDLE = 0, P_RUN = 1, P_HIT = 2, P_OVER = 3;
   int m_phase, m_rem, m_lives, m_level, m_best, m_ptr, m_waddr, m_wdata;
   bit m_frog, m_wen, m_pstart, m_pcoll;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = P_IDLE; m_rem = 0; m_lives = 0; m_level = 0; m_best = 0;
         m_ptr = 0; m_waddr = 0; m_wdata = 0; m_frog = 0; m_wen = 0;
         m_pstart = 0; m_pcoll = 0;
      end else begin
         bit srise, crise;
         srise = start && !m_pstart;
         crise = coll && !m_pcoll;
         m_pstart = start;
         m_pcoll  = coll;
         m_frog = 0;
         m_wen  = 0;
         case (m_phase)
            P_IDLE: if (srise) begin
               m_phase = P_RUN; m_lives = C_LI; m_level = 0; m_frog = 1;
            end
            P_RUN: if (crise) begin
               m_lives--; m_phase = P_HIT; m_rem = C_R;
            end else if (lvl) begin
               m_level = (m_level < 255) ? m_level + 1 : 255;
            end
            P_HIT: begin
               m_rem--;
               if (m_rem == 0) begin
                  if (m_lives == 0) begin
                     m_phase = P_OVER; m_rem = C_G;
                     if (m_level > m_best) m_best = m_level;
                     if (HIST) begin
                        m_wen = 1; m_waddr = m_ptr; m_wdata = m_level;
                        m_ptr = (m_ptr + 1) % 32;
                     end
                  end else begin
                     m_phase = P_RUN; m_frog = 1;
                  end
               end
            end
            default: begin
               m_rem--;
               if (m_rem == 0) m_phase = P_IDLE;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model active", o_Game_Active, longint'(m_phase == P_RUN));
         chk("model frog_reset", o_Frog_Reset, m_frog);
         chk("model lives", o_Lives, m_lives);
         chk("model level", o_Level, m_level);
         chk("model best", o_Best_Level, m_best);
         chk("model game_over", o_Game_Over, longint'(m_phase == P_OVER));
         chk("model write_en", o_Write_En, m_wen);
         if (!HIST) begin
            chk("model write_addr", o_Write_Addr, 0);
            chk("model write_data", o_Write_Data, 0);
         end else if (m_wen) begin
            chk("model write_addr", o_Write_Addr, m_waddr);
            chk("model write_data", o_Write_Data, m_wdata);
         end
      end
   end

   // Write-strobe monitor for the session sequence.
   int wa[$];
   int wd[$];
   always @(negedge clk) begin
      if (o_Write_En) begin
         wa.push_back(int'(o_Write_Addr));
         wd.push_back(int'(o_Write_Data));
      end
   end

   // ---------------- directed vector table ----------------
   typedef struct {
      bit s, c, l;
      int act, frog, lives, level, best, over, wen;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input int n, input bit s, input bit c, input bit l,
                               input int act, input int frog, input int lives,
                               input int level, input int best, input int over,
                               input int wen);
      vec_t v;
      v.s = s; v.c = c; v.l = l; v.act = act; v.frog = frog; v.lives = lives;
      v.level = level; v.best = best; v.over = over; v.wen = wen;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endfunction

   task automatic session(input int nlvl);
      start = 1'b0; @(negedge clk);
      start = 1'b1; @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < nlvl; k++) begin
         lvl = 1'b1; @(negedge clk);
         lvl = 1'b0; @(negedge clk);
      end
      for (int k = 0; k < 3; k++) begin
         coll = 1'b1; @(negedge clk);
         coll = 1'b0;
         repeat (C_R + 2) @(negedge clk);
      end
      repeat (C_G + 4) @(negedge clk);
   endtask

   initial begin
      //   n  s  c  l  act frog lives level best over wen
      add(1, 1, 0, 0, 1, 1, 3, 0, 0, 0, 0);   // start rise
      add(1, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0);   // held start, pulse gone
      add(1, 1, 0, 1, 1, 0, 3, 1, 0, 0, 0);
      add(1, 1, 0, 0, 1, 0, 3, 1, 0, 0, 0);
      add(1, 1, 0, 1, 1, 0, 3, 2, 0, 0, 0);
      add(1, 1, 0, 1, 1, 0, 3, 3, 0, 0, 0);
      add(1, 1, 1, 1, 0, 0, 2, 3, 0, 0, 0);   // collision beats level-up
      add(3, 1, 1, 0, 0, 0, 2, 3, 0, 0, 0);   // HIT (4 cycles total)
      add(1, 1, 0, 0, 1, 1, 2, 3, 0, 0, 0);   // respawn
      add(4, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0);   // collision held 10 cycles
      add(1, 1, 1, 0, 1, 1, 1, 3, 0, 0, 0);
      add(5, 1, 1, 0, 1, 0, 1, 3, 0, 0, 0);   // no second life lost
      add(1, 1, 0, 0, 1, 0, 1, 3, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0, 3, 0, 0, 0);   // last life
      add(3, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 3, 3, 1, 1);   // GAME_OVER entry
      add(7, 1, 0, 0, 0, 0, 0, 3, 3, 1, 0);
      add(3, 1, 0, 0, 0, 0, 0, 3, 3, 0, 0);   // IDLE, held start ignored
      add(1, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
      add(1, 1, 0, 0, 1, 1, 3, 0, 3, 0, 0);   // re-press
      add(1, 1, 1, 0, 0, 0, 2, 0, 3, 0, 0);   // into HIT

      repeat (3) @(negedge clk);
      chk("reset active", o_Game_Active, 0);
      chk("reset lives", o_Lives, 0);
      chk("reset level", o_Level, 0);
      chk("reset best", o_Best_Level, 0);
      chk("reset game_over", o_Game_Over, 0);
      chk("reset write_en", o_Write_En, 0);
      rst_n = 1'b1;

      wa.delete(); wd.delete();
      for (int i = 0; i < tbl.size(); i++) begin
         start = tbl[i].s; coll = tbl[i].c; lvl = tbl[i].l;
         @(negedge clk);
         chk($sformatf("row%0d active", i), o_Game_Active, tbl[i].act);
         chk($sformatf("row%0d frog_reset", i), o_Frog_Reset, tbl[i].frog);
         chk($sformatf("row%0d lives", i), o_Lives, tbl[i].lives);
         chk($sformatf("row%0d level", i), o_Level, tbl[i].level);
         chk($sformatf("row%0d best", i), o_Best_Level, tbl[i].best);
         chk($sformatf("row%0d game_over", i), o_Game_Over, tbl[i].over);
         chk($sformatf("row%0d write_en", i), o_Write_En, HIST ? tbl[i].wen : 0);
         if (HIST && tbl[i].wen != 0) begin
            chk($sformatf("row%0d write_addr", i), o_Write_Addr, 0);
            chk($sformatf("row%0d write_data", i), o_Write_Data, 3);
         end
      end

      // Asynchronous reset in the middle of HIT.
      start = 1'b0; coll = 1'b0; lvl = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async active", o_Game_Active, 0);
      chk("async frog_reset", o_Frog_Reset, 0);
      chk("async lives", o_Lives, 0);
      chk("async level", o_Level, 0);
      chk("async best", o_Best_Level, 0);
      chk("async game_over", o_Game_Over, 0);
      chk("async write", {o_Write_En, o_Write_Addr, o_Write_Data}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // 33 complete sessions: history address must wrap 31 -> 0.
      wa.delete(); wd.delete();
      for (int i = 0; i < 33; i++) session((i * 7) % 10);
      chk("sessions write count", wa.size(), HIST ? 33 : 0);
      if (HIST) begin
         for (int i = 0; i < wa.size() && i < 33; i++) begin
            chk($sformatf("session%0d write_addr", i), wa[i], i % 32);
            chk($sformatf("session%0d write_data", i), wd[i], (i * 7) % 10);
         end
      end
      chk("sessions best", o_Best_Level, 9);

      // Randomized stimulus against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(15) == 0) start = ~start;
         coll = ($urandom_range(5) == 0);
         lvl  = ($urandom_range(3) == 0);
         @(negedge clk);
      end

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
